// File: rtl/sr_pulse_driver.sv
// SR latch pulse driver: turns level requests into non-overlapping, minimum-width
// s/r pulses with a dead time between them, and tracks the latch output in a shadow bit.
module sr_pulse_driver #(
    parameter int PULSE_W        = 2,
    parameter int DEAD_T         = 1,
    parameter int CNT_W          = 8,
    parameter bit SKIP_REDUNDANT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_level,
    output logic req_ready,
    output logic s,
    output logic r,
    output logic done,
    output logic q_model,
    output logic q_known
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE_S = 2'd1,
        PULSE_R = 2'd2,
        DEAD    = 2'd3
    } state_t;

    // Counter load values: the count runs down to zero, so one less than the length.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEAD_T - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level, level_nxt;
    logic             done_nxt;
    logic             q_model_nxt;
    logic             q_known_nxt;

    assign req_ready = (state == IDLE);

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = level;
        done_nxt    = 1'b0;
        q_model_nxt = q_model;
        q_known_nxt = q_known;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (SKIP_REDUNDANT && q_known && (req_level == q_model)) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = req_level ? PULSE_S : PULSE_R;
                        cnt_nxt   = PULSE_LOAD;
                        level_nxt = req_level;
                    end
                end
            end
            PULSE_S, PULSE_R: begin
                if (cnt == '0) begin
                    q_model_nxt = level;
                    q_known_nxt = 1'b1;
                    if (DEAD_T > 0) begin
                        state_nxt = DEAD;
                        cnt_nxt   = DEAD_LOAD;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DEAD: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // s and r get their own flops, decoded from the next state, so the latch sees clean edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            level   <= 1'b0;
            done    <= 1'b0;
            q_model <= 1'b0;
            q_known <= 1'b0;
            s       <= 1'b0;
            r       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level   <= level_nxt;
            done    <= done_nxt;
            q_model <= q_model_nxt;
            q_known <= q_known_nxt;
            s       <= (state_nxt == PULSE_S);
            r       <= (state_nxt == PULSE_R);
        end
    end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Directed bench for sr_pulse_driver: default config (PULSE_W=2, DEAD_T=1) and a fast
// config (PULSE_W=1, DEAD_T=0). Observed vectors are {req_ready, s, r, done, q_model, q_known}.
module tb_sr_pulse_driver;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic valid = 1'b0, level = 1'b0;
    logic ready, s, r, done, q_model, q_known;

    logic f_valid = 1'b0, f_level = 1'b0;
    logic f_ready, f_s, f_r, f_done, f_q_model, f_q_known;

    int errors = 0;
    int checks = 0;

    wire [5:0] o1 = {ready, s, r, done, q_model, q_known};
    wire [5:0] f_o = {f_ready, f_s, f_r, f_done, f_q_model, f_q_known};

    sr_pulse_driver #(.PULSE_W(2), .DEAD_T(1), .CNT_W(8), .SKIP_REDUNDANT(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(valid), .req_level(level), .req_ready(ready),
        .s(s), .r(r), .done(done), .q_model(q_model), .q_known(q_known)
    );

    sr_pulse_driver #(.PULSE_W(1), .DEAD_T(0), .CNT_W(8), .SKIP_REDUNDANT(1'b1)) dut_fast (
        .clk(clk), .rst(rst), .req_valid(f_valid), .req_level(f_level), .req_ready(f_ready),
        .s(f_s), .r(f_r), .done(f_done), .q_model(f_q_model), .q_known(f_q_known)
    );

    always #5 clk = ~clk;

    // s and r must never be high together on either instance.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((s && r) || (f_s && f_r)) begin
                errors++;
                $display("FAIL overlap: s=%b r=%b f_s=%b f_r=%b want no s&r", s, r, f_s, f_r);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (o1 !== 6'b100000) begin errors++; $display("FAIL reset_hold: got %b want %b", o1, 6'b100000); end
        checks++;
        if (f_o !== 6'b100000) begin errors++; $display("FAIL reset_hold_fast: got %b want %b", f_o, 6'b100000); end
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        checks++;
        if (o1 !== 6'b100000) begin errors++; $display("FAIL reset_release: got %b want %b", o1, 6'b100000); end
        checks++;
        if (f_o !== 6'b100000) begin errors++; $display("FAIL reset_release_fast: got %b want %b", f_o, 6'b100000); end
    endtask

    task automatic test_set_pulse();
        logic [5:0] exp_seq [5] = '{6'b010000, 6'b010000, 6'b000011, 6'b100111, 6'b100011};
        valid = 1'b1;
        level = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            valid = 1'b0;
            checks++;
            if (o1 !== exp_seq[i]) begin
                errors++;
                $display("FAIL set_pulse[%0d]: got %b want %b", i, o1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_skip();
        logic [5:0] exp_seq [3] = '{6'b100111, 6'b100111, 6'b100011};
        valid = 1'b1;
        level = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) valid = 1'b0;
            checks++;
            if (o1 !== exp_seq[i]) begin
                errors++;
                $display("FAIL skip[%0d]: got %b want %b", i, o1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_reset_pulse();
        logic [5:0] exp_seq [5] = '{6'b001011, 6'b001011, 6'b000001, 6'b100101, 6'b100001};
        valid = 1'b1;
        level = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            valid = 1'b0;
            checks++;
            if (o1 !== exp_seq[i]) begin
                errors++;
                $display("FAIL reset_pulse[%0d]: got %b want %b", i, o1, exp_seq[i]);
            end
        end
    endtask

    // Valid held high, level flipped after each pulse starts: pulses every PULSE_W+DEAD_T+1 cycles.
    task automatic test_back_to_back();
        logic prev_sr = 1'b0;
        logic expect_s = 1'b1;
        int   starts = 0;
        valid = 1'b1;
        level = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            if ((s | r) && !prev_sr) begin
                checks++;
                if (i != starts * 4 || s !== expect_s || r !== !expect_s) begin
                    errors++;
                    $display("FAIL b2b_start: cycle %0d s=%b r=%b want cycle %0d s=%b r=%b",
                             i, s, r, starts * 4, expect_s, !expect_s);
                end
                starts++;
                expect_s = !expect_s;
                level = ~level;
            end
            prev_sr = s | r;
            if (i == 15) valid = 1'b0;
        end
        checks++;
        if (starts != 4) begin errors++; $display("FAIL b2b_count: got %0d want %0d", starts, 4); end
        step();
        checks++;
        if (o1 !== 6'b100001) begin errors++; $display("FAIL b2b_end: got %b want %b", o1, 6'b100001); end
    endtask

    task automatic test_async_reset();
        logic [5:0] exp_seq [4] = '{6'b001000, 6'b001000, 6'b000001, 6'b100101};
        valid = 1'b1;
        level = 1'b1;
        step();
        valid = 1'b0;
        step();
        checks++;
        if (o1 !== 6'b010001) begin errors++; $display("FAIL async_pre: got %b want %b", o1, 6'b010001); end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (o1 !== 6'b100000) begin errors++; $display("FAIL async_drop: got %b want %b", o1, 6'b100000); end
        #1 rst = 1'b0;
        valid = 1'b1;
        level = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            valid = 1'b0;
            checks++;
            if (o1 !== exp_seq[i]) begin
                errors++;
                $display("FAIL async_post[%0d]: got %b want %b", i, o1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_fast_config();
        logic [5:0] exp_seq [5] = '{6'b010000, 6'b100111, 6'b001011, 6'b100101, 6'b100001};
        f_valid = 1'b1;
        f_level = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 0) f_level = 1'b0;
            if (i == 2) f_valid = 1'b0;
            checks++;
            if (f_o !== exp_seq[i]) begin
                errors++;
                $display("FAIL fast[%0d]: got %b want %b", i, f_o, exp_seq[i]);
            end
        end
    endtask

    // Random valid/level every cycle; only cycles with ready high may launch anything.
    task automatic test_random_ignore();
        logic exp_qm = 1'b0;
        logic exp_qk = 1'b1;
        logic acc, acc_l;
        for (int i = 0; i < 80; i++) begin
            valid = 1'($urandom_range(0, 1));
            level = 1'($urandom_range(0, 1));
            acc   = ready && valid;
            acc_l = level;
            step();
            if (acc) begin
                checks++;
                if (exp_qk && acc_l == exp_qm) begin
                    if (done !== 1'b1 || s !== 1'b0 || r !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_skip[%0d]: done=%b s=%b r=%b want done=1 s=0 r=0", i, done, s, r);
                    end
                end else if (s !== acc_l || r !== !acc_l) begin
                    errors++;
                    $display("FAIL rand_pulse[%0d]: s=%b r=%b want s=%b r=%b", i, s, r, acc_l, !acc_l);
                end
                exp_qm = acc_l;
                exp_qk = 1'b1;
            end
        end
        valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({ready, q_model, q_known} !== {1'b1, exp_qm, exp_qk}) begin
            errors++;
            $display("FAIL rand_final: ready/q_model/q_known got %b want %b",
                     {ready, q_model, q_known}, {1'b1, exp_qm, exp_qk});
        end
    endtask

    initial begin
        test_reset();
        test_set_pulse();
        test_skip();
        test_reset_pulse();
        test_back_to_back();
        test_async_reset();
        test_fast_config();
        test_random_ignore();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
